// File: rtl/pagerank_pkg.sv
// Shared types and default widths for the pagerank update arbiter slice.
package pagerank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } arb_state_t;

    localparam int DEFAULT_ID_W   = 32;
    localparam int DEFAULT_DATA_W = 64;

endpackage

// File: rtl/pagerank_update_arbiter_rr_pick.sv
// Circular priority select: first set bit of pending at or after rr_ptr.
module rr_pick #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    int j;

    // Scanning from the far end lets the nearest pending index win last.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        j         = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (pending[j]) begin
                winner    = IDX_W'(j);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pagerank_update_arbiter.sv
// Round-robin arbiter sharing one gather/update port among scatter partitions.
// Define PAGERANK_ARB_STATS_EN to add saturating grant_count/drop_count outputs.
module pagerank_update_arbiter
    import pagerank_pkg::*;
#(
    parameter  int NUM_SCATTER = 4,
    parameter  int ID_W        = DEFAULT_ID_W,
    parameter  int DATA_W      = DEFAULT_DATA_W,
    localparam int IDX_W       = $clog2(NUM_SCATTER)
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [NUM_SCATTER-1:0]              req,
    input  logic [NUM_SCATTER-1:0][ID_W-1:0]    req_node_id,
    input  logic [NUM_SCATTER-1:0][DATA_W-1:0]  req_value,
    input  logic [NUM_SCATTER-1:0]              scatter_done,
    output logic [NUM_SCATTER-1:0]              update_complete,
    output logic                                upd_valid,
    output logic [ID_W-1:0]                     upd_node_id,
    output logic [DATA_W-1:0]                   upd_value,
    input  logic                                upd_ack,
    output logic                                iter_done,
`ifdef PAGERANK_ARB_STATS_EN
    output logic [NUM_SCATTER-1:0][31:0]        grant_count,
    output logic [31:0]                         drop_count,
`endif
    output logic                                proto_err
);

    arb_state_t                          state;
    logic [NUM_SCATTER-1:0]              pending;
    logic [NUM_SCATTER-1:0]              capture;
    logic [NUM_SCATTER-1:0]              drop;
    logic [NUM_SCATTER-1:0][ID_W-1:0]    slot_id;
    logic [NUM_SCATTER-1:0][DATA_W-1:0]  slot_val;
    logic [IDX_W-1:0]                    rr_ptr;
    logic [IDX_W-1:0]                    grant_idx;
    logic [IDX_W-1:0]                    winner;
    logic                                any_valid;

    rr_pick #(.N(NUM_SCATTER)) u_rr_pick (
        .pending   (pending),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // A slot being released this cycle may accept a fresh request.
    always_comb begin
        capture = '0;
        drop    = '0;
        for (int k = 0; k < NUM_SCATTER; k++) begin
            if (req[k]) begin
                if (!pending[k] || (state == RELEASE && grant_idx == IDX_W'(k))) begin
                    capture[k] = 1'b1;
                end else begin
                    drop[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending   <= '0;
            slot_id   <= '0;
            slot_val  <= '0;
            proto_err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_SCATTER; k++) begin
                if (capture[k]) begin
                    pending[k]  <= 1'b1;
                    slot_id[k]  <= req_node_id[k];
                    slot_val[k] <= req_value[k];
                end else if (state == RELEASE && grant_idx == IDX_W'(k)) begin
                    pending[k] <= 1'b0;
                end
            end
            if (|drop) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= IDLE;
            grant_idx       <= '0;
            rr_ptr          <= '0;
            upd_valid       <= 1'b0;
            upd_node_id     <= '0;
            upd_value       <= '0;
            update_complete <= '0;
        end else begin
            case (state)
                IDLE: begin
                    update_complete <= '0;
                    if (any_valid) begin
                        grant_idx   <= winner;
                        upd_valid   <= 1'b1;
                        upd_node_id <= slot_id[winner];
                        upd_value   <= slot_val[winner];
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (upd_ack) begin
                        upd_valid       <= 1'b0;
                        upd_node_id     <= '0;
                        upd_value       <= '0;
                        update_complete <= NUM_SCATTER'(1) << grant_idx;
                        state           <= RELEASE;
                    end
                end
                RELEASE: begin
                    update_complete <= '0;
                    rr_ptr <= (grant_idx == IDX_W'(NUM_SCATTER - 1)) ? '0 : grant_idx + 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign iter_done = (&scatter_done) && (pending == '0) && (state == IDLE);

`ifdef PAGERANK_ARB_STATS_EN
    logic [32:0] drop_sum;

    assign drop_sum = {1'b0, drop_count} + 33'($countones(drop));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            grant_count <= '0;
            drop_count  <= '0;
        end else begin
            drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            if (state == RELEASE && grant_count[grant_idx] != 32'hFFFF_FFFF) begin
                grant_count[grant_idx] <= grant_count[grant_idx] + 32'd1;
            end
        end
    end
`endif

endmodule
